// File: rtl/current_sense_adc_if.sv
// Pin-level bundle between the current-sense SPI master, its ADC and the status logic.
// The master modport is the SPI master side; the slave modport is the ADC/consumer side.
interface current_sense_adc_if;
    logic        enable;
    logic        CS_CLK;
    logic        CS;
    logic        CS_MISO;
    logic [12:0] current;
    logic        current_valid;
    logic        frame_error;

    modport master (
        input  enable,
        input  CS_MISO,
        output CS_CLK,
        output CS,
        output current,
        output current_valid,
        output frame_error
    );

    modport slave (
        output enable,
        output CS_MISO,
        input  CS_CLK,
        input  CS,
        input  current,
        input  current_valid,
        input  frame_error
    );
endinterface

// File: rtl/current_sense_adc.sv
// SPI master for the 12-bit motor current-sense ADC: periodic 16-bit frames, frame check,
// offset correction and a 2^AVG_LOG2 boxcar average driven out as a signed 13-bit current.
module current_sense_adc #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1600,
    parameter int unsigned ZERO_OFFSET   = 2048,
    parameter int unsigned AVG_LOG2      = 2
) (
    input  logic                CLK,
    input  logic                reset,
    current_sense_adc_if.master bus
);

    localparam int unsigned PeriodW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned AccW    = 13 + AVG_LOG2;
    localparam int unsigned CntW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [PeriodW-1:0] PeriodLast = PeriodW'(SAMPLE_PERIOD - 1);
    localparam logic [DivW-1:0]    DivLast    = DivW'(CLK_DIV - 1);
    localparam logic [CntW-1:0]    CntLast    = CntW'((1 << AVG_LOG2) - 1);
    localparam logic [12:0]        Offset     = 13'(ZERO_OFFSET);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StShift,
        StQuiet
    } state_e;

    state_e                 state_q, state_d;
    logic [DivW-1:0]        div_q, div_d;
    logic [3:0]             bit_q, bit_d;
    logic                   cs_q, cs_d;
    logic                   sck_q, sck_d;
    logic [15:0]            shift_q, shift_d;
    logic [PeriodW-1:0]     period_q, period_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic signed [12:0]     current_q, current_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    logic                   div_last;
    logic                   idle_ok;
    logic                   start;
    logic [12:0]            diff;
    logic signed [AccW-1:0] diff_ext;
    logic signed [AccW-1:0] acc_sum;
    logic signed [12:0]     avg;

    assign div_last = (div_q == DivLast);
    // The last QUIET cycle counts as idle so back-to-back frames need no extra gap cycle.
    assign idle_ok  = (state_q == StIdle) || ((state_q == StQuiet) && div_last);
    assign start    = bus.enable && (period_q == PeriodLast) && idle_ok;

    assign diff     = {1'b0, shift_q[11:0]} - Offset;
    assign diff_ext = AccW'($signed(diff));
    assign acc_sum  = acc_q + diff_ext;
    assign avg      = 13'(acc_sum >>> AVG_LOG2);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        cs_d      = cs_q;
        sck_d     = sck_q;
        shift_d   = shift_q;
        period_d  = period_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        current_d = current_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        // Saturate at the last count until the FSM is free to start the next frame.
        if (!bus.enable) begin
            period_d = '0;
        end else if (period_q == PeriodLast) begin
            if (start) begin
                period_d = '0;
            end
        end else begin
            period_d = period_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSetup;
                    cs_d    = 1'b0;
                    sck_d   = 1'b1;
                    div_d   = '0;
                end
            end

            StSetup: begin
                if (div_last) begin
                    state_d = StShift;
                    sck_d   = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            StShift: begin
                if (!div_last) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d   = 1'b1;
                        shift_d = {shift_q[14:0], bus.CS_MISO};
                    end else if (bit_q == 4'd15) begin
                        state_d = StQuiet;
                        cs_d    = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        bit_d = bit_q + 1'b1;
                    end
                end
            end

            StQuiet: begin
                // Results land in the cycle after CS rises.
                if (div_q == '0) begin
                    if (shift_q[15:12] != 4'd0) begin
                        err_d = 1'b1;
                    end else if (cnt_q == CntLast) begin
                        current_d = avg;
                        valid_d   = 1'b1;
                        acc_d     = '0;
                        cnt_d     = '0;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                if (!div_last) begin
                    div_d = div_q + 1'b1;
                end else if (start) begin
                    state_d = StSetup;
                    cs_d    = 1'b0;
                    div_d   = '0;
                end else begin
                    state_d = StIdle;
                    div_d   = '0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_q     <= '0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b1;
            shift_q   <= '0;
            period_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            current_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            cs_q      <= cs_d;
            sck_q     <= sck_d;
            shift_q   <= shift_d;
            period_q  <= period_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            current_q <= current_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign bus.CS            = cs_q;
    assign bus.CS_CLK        = sck_q;
    assign bus.current       = current_q;
    assign bus.current_valid = valid_q;
    assign bus.frame_error   = err_q;

endmodule

// File: tb/tb_current_sense_adc.sv
// Bench for current_sense_adc: four parameterisations, an ADC model per instance and a
// scoreboard of expected averaged currents for the default-parameter instance.
`timescale 1ns/1ps
module tb_current_sense_adc;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0]        adc_word [4];
    logic [15:0]        adc0_q   [$];
    logic signed [12:0] exp0_q   [$];
    logic signed [12:0] exp1_q   [$];

    current_sense_adc_if bus [4] ();

    current_sense_adc u_dut0 (
        .CLK   (clk),
        .reset (rst0),
        .bus   (bus[0])
    );

    current_sense_adc #(
        .SAMPLE_PERIOD (200),
        .AVG_LOG2      (0)
    ) u_dut1 (
        .CLK   (clk),
        .reset (rst1),
        .bus   (bus[1])
    );

    current_sense_adc #(
        .SAMPLE_PERIOD (200),
        .ZERO_OFFSET   (0),
        .AVG_LOG2      (0)
    ) u_dut2 (
        .CLK   (clk),
        .reset (rst1),
        .bus   (bus[2])
    );

    current_sense_adc #(
        .SAMPLE_PERIOD (50)
    ) u_dut3 (
        .CLK   (clk),
        .reset (rst1),
        .bus   (bus[3])
    );

    // ADC model: loads a word at CS fall, presents the next bit on each SCK fall.
    for (genvar g = 0; g < 4; g++) begin : g_adc
        logic [15:0] sh;
        initial begin
            bus[g].CS_MISO = 1'b0;
            forever begin
                @(negedge bus[g].CS);
                if (g == 0 && adc0_q.size() > 0) sh = adc0_q.pop_front();
                else sh = adc_word[g];
                for (int b = 0; b < 16; b++) begin
                    @(negedge bus[g].CS_CLK or posedge bus[g].CS);
                    if (bus[g].CS === 1'b1) break;
                    bus[g].CS_MISO = sh[15];
                    sh = {sh[14:0], 1'b0};
                end
            end
        end
    end

    function automatic logic signed [12:0] avg_of(input int s, input int n);
        int q;
        if (s >= 0) q = s / n;
        else q = -((-s + n - 1) / n);
        return 13'(q);
    endfunction

    task automatic wait_cs0_rise(input int limit, output bit ok);
        logic prev;
        int   n;
        ok   = 1'b0;
        prev = bus[0].CS;
        n    = 0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (prev === 1'b0 && bus[0].CS === 1'b1) begin
                ok = 1'b1;
                break;
            end
            prev = bus[0].CS;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus[0].CS !== 1'b1) begin
            failures++; $display("FAIL reset_cs: got %b want 1", bus[0].CS);
        end
        checks++;
        if (bus[0].CS_CLK !== 1'b1) begin
            failures++; $display("FAIL reset_sck: got %b want 1", bus[0].CS_CLK);
        end
        checks++;
        if (bus[0].current !== 13'd0) begin
            failures++; $display("FAIL reset_current: got %0d want 0", $signed(bus[0].current));
        end
        checks++;
        if ({bus[0].current_valid, bus[0].frame_error} !== 2'b00) begin
            failures++;
            $display("FAIL reset_strobes: got %b%b want 00", bus[0].current_valid,
                     bus[0].frame_error);
        end
        checks++;
        if ({bus[3].CS, bus[3].CS_CLK} !== 2'b11) begin
            failures++; $display("FAIL reset_cs_b2b: got %b%b want 11", bus[3].CS, bus[3].CS_CLK);
        end
        rst0 = 1'b0;
        rst1 = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (bus[0].CS !== 1'b1) begin
            failures++; $display("FAIL disabled_idle_cs: got %b want 1", bus[0].CS);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int lo;
        int hi;
        bus[3].enable = 1'b1;
        n = 0;
        while (bus[3].CS !== 1'b0 && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (n != 50) begin
            failures++; $display("FAIL b2b_first_frame: got %0d cycles want 50", n);
        end
        for (int p = 0; p < 2; p++) begin
            lo = 0;
            while (bus[3].CS === 1'b0 && lo < 400) begin @(negedge clk); lo++; end
            hi = 0;
            while (bus[3].CS !== 1'b0 && hi < 400) begin @(negedge clk); hi++; end
            checks++;
            if (lo != 132) begin
                failures++; $display("FAIL b2b_cs_low: got %0d cycles want 132", lo);
            end
            checks++;
            if (hi != 4) begin
                failures++; $display("FAIL b2b_cs_high: got %0d cycles want 4", hi);
            end
        end
        bus[3].enable = 1'b0;
    endtask

    task automatic test_no_average();
        int                 n;
        logic signed [12:0] e;
        adc_word[1] = 16'h0FFF;
        adc_word[2] = 16'h0FFF;
        exp1_q.push_back(13'sd2047);
        bus[1].enable = 1'b1;
        bus[2].enable = 1'b1;
        n = 0;
        while (bus[1].current_valid !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (n >= 1000 || exp1_q.size() == 0) begin
            failures++; $display("FAIL noavg_first_valid: waited %0d cycles", n);
        end else begin
            e = exp1_q.pop_front();
            if (bus[1].current !== e) begin
                failures++;
                $display("FAIL noavg_max: got %0d want %0d", $signed(bus[1].current), e);
            end
        end
        checks++;
        if ({bus[2].current_valid, bus[2].current} !== {1'b1, 13'd4095}) begin
            failures++;
            $display("FAIL nooffset_max: got valid=%b %0d want valid=1 4095",
                     bus[2].current_valid, $signed(bus[2].current));
        end
        adc_word[1] = 16'h0000;
        exp1_q.push_back(-13'sd2048);
        n = 0;
        do begin @(negedge clk); n++; end
        while (bus[1].current_valid !== 1'b1 && n < 1000);
        checks++;
        if (n != 200) begin
            failures++; $display("FAIL noavg_period: got %0d cycles want 200", n);
        end
        checks++;
        if (exp1_q.size() == 0) begin
            failures++; $display("FAIL noavg_min: no expected value queued");
        end else begin
            e = exp1_q.pop_front();
            if (bus[1].current !== e) begin
                failures++;
                $display("FAIL noavg_min: got %0d want %0d", $signed(bus[1].current), e);
            end
        end
        bus[1].enable = 1'b0;
        bus[2].enable = 1'b0;
    endtask

    task automatic test_frame_timing();
        int                 n;
        int                 lo;
        int                 hi;
        int                 rises;
        logic               prev;
        logic signed [12:0] e;
        adc_word[0] = 16'h0800;
        exp0_q.push_back(13'sd0);
        exp0_q.push_back(13'sd0);
        bus[0].enable = 1'b1;
        n = 0;
        while (bus[0].CS !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
        checks++;
        if (n != 1600) begin
            failures++; $display("FAIL first_frame_delay: got %0d cycles want 1600", n);
        end
        lo    = 0;
        rises = 0;
        prev  = bus[0].CS_CLK;
        while (bus[0].CS === 1'b0 && lo < 400) begin
            @(negedge clk);
            lo++;
            if (bus[0].CS_CLK === 1'b1 && prev === 1'b0) rises++;
            prev = bus[0].CS_CLK;
        end
        checks++;
        if (lo != 132) begin
            failures++; $display("FAIL cs_low_len: got %0d cycles want 132", lo);
        end
        checks++;
        if (rises != 16) begin
            failures++; $display("FAIL sck_rises: got %0d want 16", rises);
        end
        hi = 0;
        while (bus[0].CS !== 1'b0 && hi < 4000) begin @(negedge clk); hi++; end
        checks++;
        if (lo + hi != 1600) begin
            failures++; $display("FAIL sample_period: got %0d cycles want 1600", lo + hi);
        end
        n = 0;
        while (bus[0].current_valid !== 1'b1 && n < 8000) begin @(negedge clk); n++; end
        checks++;
        if (n >= 8000 || exp0_q.size() == 0) begin
            failures++; $display("FAIL first_window: no valid after %0d cycles", n);
        end else begin
            e = exp0_q.pop_front();
            if (bus[0].current !== e) begin
                failures++;
                $display("FAIL first_window: got %0d want %0d", $signed(bus[0].current), e);
            end
        end
        n = 0;
        do begin @(negedge clk); n++; end
        while (bus[0].current_valid !== 1'b1 && n < 8000);
        checks++;
        if (n != 6400) begin
            failures++; $display("FAIL valid_period: got %0d cycles want 6400", n);
        end
        checks++;
        if (exp0_q.size() == 0) begin
            failures++; $display("FAIL second_window: no expected value queued");
        end else begin
            e = exp0_q.pop_front();
            if (bus[0].current !== e) begin
                failures++;
                $display("FAIL second_window: got %0d want %0d", $signed(bus[0].current), e);
            end
        end
    endtask

    task automatic test_averaging();
        logic [15:0]        win [3][4];
        int                 s;
        bit                 ok;
        logic signed [12:0] e;
        win[0] = '{16'd2049, 16'd2049, 16'd2049, 16'd2046};
        win[1] = '{16'd2047, 16'd2047, 16'd2047, 16'd2050};
        win[2] = '{16'h0FFF, 16'h0000, 16'h0C00, 16'h0100};
        for (int w = 0; w < 3; w++) begin
            s = 0;
            for (int f = 0; f < 4; f++) begin
                adc0_q.push_back(win[w][f]);
                s += int'(win[w][f][11:0]) - 2048;
            end
            exp0_q.push_back(avg_of(s, 4));
        end
        for (int k = 0; k < 12; k++) begin
            wait_cs0_rise(3000, ok);
            checks++;
            if (!ok) begin
                failures++; $display("FAIL avg_frame_%0d: CS never rose", k);
            end
            @(negedge clk);
            checks++;
            if (k % 4 != 3) begin
                if (bus[0].current_valid !== 1'b0) begin
                    failures++; $display("FAIL avg_early_valid_%0d: got 1 want 0", k);
                end
            end else if (bus[0].current_valid !== 1'b1) begin
                failures++; $display("FAIL avg_valid_%0d: got 0 want 1", k);
            end else if (exp0_q.size() == 0) begin
                failures++; $display("FAIL avg_value_%0d: no expected value queued", k);
            end else begin
                e = exp0_q.pop_front();
                if (bus[0].current !== e) begin
                    failures++;
                    $display("FAIL avg_value_%0d: got %0d want %0d", k,
                             $signed(bus[0].current), e);
                end
            end
        end
    endtask

    task automatic test_frame_error();
        logic [15:0]        words [5];
        logic signed [12:0] prior;
        logic signed [12:0] e;
        bit                 ok;
        words = '{16'h0900, 16'h4900, 16'h0A00, 16'h0700, 16'h0E00};
        prior = -13'sd193;
        for (int f = 0; f < 5; f++) adc0_q.push_back(words[f]);
        exp0_q.push_back(avg_of(256 + 512 - 256 + 1536, 4));
        for (int k = 0; k < 5; k++) begin
            wait_cs0_rise(3000, ok);
            checks++;
            if (!ok || {bus[0].frame_error, bus[0].current_valid} !== 2'b00) begin
                failures++;
                $display("FAIL err_early_%0d: rose=%0d err/valid=%b%b want 1 00", k, ok,
                         bus[0].frame_error, bus[0].current_valid);
            end
            @(negedge clk);
            checks++;
            if ({bus[0].frame_error, bus[0].current_valid} !== {k == 1, k == 4}) begin
                failures++;
                $display("FAIL err_strobes_%0d: got %b%b want %b%b", k, bus[0].frame_error,
                         bus[0].current_valid, k == 1, k == 4);
            end
            if (k == 1) begin
                checks++;
                if (bus[0].current !== prior) begin
                    failures++;
                    $display("FAIL err_current_held: got %0d want %0d",
                             $signed(bus[0].current), prior);
                end
            end
            if (k == 4) begin
                checks++;
                if (exp0_q.size() == 0) begin
                    failures++; $display("FAIL err_window: no expected value queued");
                end else begin
                    e = exp0_q.pop_front();
                    if (bus[0].current !== e) begin
                        failures++;
                        $display("FAIL err_window: got %0d want %0d", $signed(bus[0].current), e);
                    end
                end
            end
            @(negedge clk);
            checks++;
            if ({bus[0].frame_error, bus[0].current_valid} !== 2'b00) begin
                failures++;
                $display("FAIL err_pulse_width_%0d: got %b%b want 00", k, bus[0].frame_error,
                         bus[0].current_valid);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int                 n;
        int                 rises;
        logic               prev;
        bit                 ok;
        logic signed [12:0] e;
        adc0_q.push_back(16'h0C00);
        wait_cs0_rise(3000, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL rst_setup_frame: CS never rose");
        end
        n = 0;
        while (bus[0].CS !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        rises = 0;
        prev  = bus[0].CS_CLK;
        n     = 0;
        while (rises < 8 && n < 400) begin
            @(negedge clk);
            n++;
            if (bus[0].CS_CLK === 1'b1 && prev === 1'b0) rises++;
            prev = bus[0].CS_CLK;
        end
        checks++;
        if (rises != 8 || bus[0].CS !== 1'b0) begin
            failures++; $display("FAIL rst_sck_edge: got %0d rises cs=%b want 8 0", rises,
                                 bus[0].CS);
        end
        rst0          = 1'b1;
        bus[0].enable = 1'b0;
        #1;
        checks++;
        if ({bus[0].CS, bus[0].CS_CLK} !== 2'b11) begin
            failures++; $display("FAIL rst_async_pins: got %b%b want 11", bus[0].CS, bus[0].CS_CLK);
        end
        checks++;
        if (bus[0].current !== 13'd0) begin
            failures++; $display("FAIL rst_current: got %0d want 0", $signed(bus[0].current));
        end
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
        for (int f = 0; f < 4; f++) adc0_q.push_back(16'h0804);
        exp0_q.push_back(avg_of(16, 4));
        bus[0].enable = 1'b1;
        n = 0;
        while (bus[0].CS !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
        checks++;
        if (n != 1600) begin
            failures++; $display("FAIL rst_restart_delay: got %0d cycles want 1600", n);
        end
        for (int k = 0; k < 4; k++) begin
            wait_cs0_rise(3000, ok);
            @(negedge clk);
            checks++;
            if (!ok || bus[0].current_valid !== (k == 3)) begin
                failures++;
                $display("FAIL rst_window_valid_%0d: rose=%0d got %b want %b", k, ok,
                         bus[0].current_valid, k == 3);
            end else if (k == 3) begin
                checks++;
                if (exp0_q.size() == 0) begin
                    failures++; $display("FAIL rst_window: no expected value queued");
                end else begin
                    e = exp0_q.pop_front();
                    if (bus[0].current !== e) begin
                        failures++;
                        $display("FAIL rst_window: got %0d want %0d", $signed(bus[0].current), e);
                    end
                end
            end
        end
        bus[0].enable = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0          = 1'b1;
        rst1          = 1'b1;
        bus[0].enable = 1'b0;
        bus[1].enable = 1'b0;
        bus[2].enable = 1'b0;
        bus[3].enable = 1'b0;
        adc_word[0]   = 16'h0800;
        adc_word[1]   = 16'h0800;
        adc_word[2]   = 16'h0800;
        adc_word[3]   = 16'h0800;

        test_reset();
        test_back_to_back();
        test_no_average();
        test_frame_timing();
        test_averaging();
        test_frame_error();
        test_reset_mid_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
